// File: rtl/led_pkg.sv
// Shared types and constants for the LED pattern sequencer and its
// downstream active-low 3-to-8 decoder interface.
package led_pkg;

    // Width of the LED index driven to the decoder.
    localparam int LED_IDX_W = 3;

    // The decoder lights an LED only for this exact enable code.
    localparam logic [2:0] EN_ACTIVE = 3'b100;
    localparam logic [2:0] EN_BLANK  = 3'b000;

    typedef enum logic [1:0] {
        MANUAL     = 2'd0,
        CHASE_UP   = 2'd1,
        CHASE_DOWN = 2'd2,
        BLANK      = 2'd3
    } mode_t;

    // Mode button cycles through the four modes in a fixed ring.
    function automatic mode_t next_mode(input mode_t m);
        mode_t n;
        case (m)
            MANUAL:     n = CHASE_UP;
            CHASE_UP:   n = CHASE_DOWN;
            CHASE_DOWN: n = BLANK;
            default:    n = MANUAL;
        endcase
        return n;
    endfunction

    // Only the two chase modes run the step timer and honour pause.
    function automatic logic is_chase(input mode_t m);
        return (m == CHASE_UP) || (m == CHASE_DOWN);
    endfunction

endpackage

// File: rtl/led_pattern_sequencer_sync_debounce.sv
// Two-flop synchroniser followed by an independent debounce filter per bit.
// A debounced bit only follows its synchronised input after that input has
// disagreed with it on DEBOUNCE_CYCLES consecutive samples.
module sync_debounce #(
    parameter int WIDTH           = 5,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din_raw,
    output logic [WIDTH-1:0] dout
);

    // A single-sample filter still needs a one-bit counter to keep widths legal.
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;
    logic [WIDTH-1:0] deb_q;
    logic [CNT_W-1:0] cnt_q [WIDTH];

    // Metastability guard: two flops between the asynchronous pins and logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= din_raw;
            sync_p1 <= sync_p0;
        end
    end

    // Per-bit run-length filter; any agreeing sample restarts the run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q <= '0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync_p1[i] != deb_q[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        deb_q[i] <= sync_p1[i];
                        cnt_q[i] <= '0;
                    end else begin
                        cnt_q[i] <= cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_q[i] <= '0;
                end
            end
        end
    end

    assign dout = deb_q;

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives the index and enable code of an active-low 3-to-8 LED decoder.
// Switches select an LED directly in MANUAL mode; the chase modes walk a
// position up or down once every TICK_DIV cycles; BLANK turns all LEDs off.
module led_pattern_sequencer
    import led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [LED_IDX_W-1:0] sw_raw,
    input  logic                 btn_mode_raw,
    input  logic                 btn_pause_raw,
    output logic [LED_IDX_W-1:0] sel,
    output logic [2:0]           en,
    output logic [1:0]           mode
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Debounced view of the inputs: {pause, mode, switches}.
    logic [4:0]           raw_bus;
    logic [4:0]           deb_bus;
    logic [LED_IDX_W-1:0] sw_deb;
    logic                 mode_deb;
    logic                 pause_deb;

    // Press detection.
    logic mode_prev_q;
    logic pause_prev_q;
    logic mode_press;
    logic pause_press;

    // Sequencer state and its next values.
    mode_t                mode_q,   mode_d;
    logic [LED_IDX_W-1:0] pos_q,    pos_d;
    logic [TICK_W-1:0]    tick_q,   tick_d;
    logic                 paused_q, paused_d;
    logic                 tick_evt;

    // Registered decoder outputs and their next values.
    logic [LED_IDX_W-1:0] sel_d;
    logic [2:0]           en_d;

    assign raw_bus = {btn_pause_raw, btn_mode_raw, sw_raw};

    sync_debounce #(
        .WIDTH           (5),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_sync_debounce (
        .clk     (clk),
        .rst     (rst),
        .din_raw (raw_bus),
        .dout    (deb_bus)
    );

    assign sw_deb    = deb_bus[LED_IDX_W-1:0];
    assign mode_deb  = deb_bus[3];
    assign pause_deb = deb_bus[4];

    // Previous-cycle copies of the debounced buttons for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_prev_q  <= 1'b0;
            pause_prev_q <= 1'b0;
        end else begin
            mode_prev_q  <= mode_deb;
            pause_prev_q <= pause_deb;
        end
    end

    // A press lasts exactly one cycle regardless of how long the button is held.
    assign mode_press  = mode_deb  & ~mode_prev_q;
    assign pause_press = pause_deb & ~pause_prev_q;

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q   <= MANUAL;
            pos_q    <= '0;
            tick_q   <= '0;
            paused_q <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            pos_q    <= pos_d;
            tick_q   <= tick_d;
            paused_q <= paused_d;
        end
    end

    // Next-state: a mode change overrides any tick or pause in the same cycle.
    always_comb begin
        mode_d   = mode_q;
        pos_d    = pos_q;
        tick_d   = tick_q;
        paused_d = paused_q;
        tick_evt = 1'b0;
        if (mode_press) begin
            mode_d   = next_mode(mode_q);
            pos_d    = sw_deb;
            tick_d   = '0;
            paused_d = 1'b0;
        end else if (is_chase(mode_q)) begin
            if (pause_press) begin
                paused_d = ~paused_q;
            end
            // The timer follows the pause state held before this edge.
            if (!paused_q) begin
                if (tick_q == TICK_LAST) begin
                    tick_d   = '0;
                    tick_evt = 1'b1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            // Position arithmetic wraps naturally in LED_IDX_W bits.
            if (tick_evt) begin
                if (mode_q == CHASE_UP) begin
                    pos_d = pos_q + 1'b1;
                end else begin
                    pos_d = pos_q - 1'b1;
                end
            end
        end else begin
            tick_d = '0;
        end
    end

    // Output selection from the state held before the edge.
    always_comb begin
        sel_d = sel;
        en_d  = EN_ACTIVE;
        case (mode_q)
            MANUAL: begin
                sel_d = sw_deb;
                en_d  = EN_ACTIVE;
            end
            CHASE_UP, CHASE_DOWN: begin
                sel_d = pos_q;
                en_d  = EN_ACTIVE;
            end
            default: begin
                sel_d = sel;
                en_d  = EN_BLANK;
            end
        endcase
    end

    // Decoder-facing output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel <= '0;
            en  <= EN_BLANK;
        end else begin
            sel <= sel_d;
            en  <= en_d;
        end
    end

    assign mode = mode_q;

endmodule
